// File: rtl/scrypt_nonce_dispatcher.sv
// Nonce dispatcher around scrypt_ipcore: issues one header per nonce, pairs hashes with nonces in order,
// reports hashes meeting the target. Optional build macro STOP_ON_FIRST_HIT_EN ends issuing at the first hit.
module scrypt_nonce_dispatcher #(
   parameter int WIDTH_IN   = 640,
   parameter int WIDTH_OUT  = 256,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 job_valid,
   output logic                 job_ready,
   input  logic [WIDTH_IN-1:0]  job_header,
   input  logic [31:0]          job_nonce_start,
   input  logic [31:0]          job_nonce_count,
   input  logic [WIDTH_OUT-1:0] job_target,
   input  logic                 abort,
   output logic [WIDTH_IN-1:0]  blockheader,
   output logic                 valid_in,
   input  logic                 scrypt_ready,
   input  logic [WIDTH_OUT-1:0] out,
   input  logic                 valid_out,
   output logic                 out_ready,
   output logic                 found_valid,
   input  logic                 found_ready,
   output logic [31:0]          found_nonce,
   output logic [WIDTH_OUT-1:0] found_hash,
   output logic                 busy,
   output logic                 done,
   output logic                 err_orphan,
   output logic [1:0]           dbg_state
);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] LP_FULL = CW'(FIFO_DEPTH);

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_ISSUE = 2'd1, S_DRAIN = 2'd2, S_DONE = 2'd3} state_t;

   // Handshakes: a transfer happens on a rising edge where the source's valid and the sink's ready are both 1.
   state_t                 r_state, w_next;
   logic [WIDTH_IN-1:32]   r_template;
   logic [31:0]            r_nonce, r_remaining;
   logic [WIDTH_OUT-1:0]   r_target;
   logic [WIDTH_IN-1:0]    r_blockheader;
   logic                   r_valid_in;
   logic [31:0]            r_fifo [FIFO_DEPTH];
   logic [PW-1:0]          r_wr_ptr, r_rd_ptr;
   logic [CW-1:0]          r_count;
   logic                   r_found_valid;
   logic [31:0]            r_found_nonce;
   logic [WIDTH_OUT-1:0]   r_found_hash;
   logic                   r_err_orphan;
   logic w_full, w_empty, w_acc, w_pop, w_hit, w_report, w_issue, w_stop, w_job_acc;
   logic w_unused;

   function automatic logic [WIDTH_OUT-1:0] f_bswap(input logic [WIDTH_OUT-1:0] d);
      logic [WIDTH_OUT-1:0] r;
      for (int i = 0; i < WIDTH_OUT/8; i++) r[8*i +: 8] = d[WIDTH_OUT-8-8*i +: 8];
      return r;
   endfunction

   assign w_unused  = ^job_header[31:0];
   assign w_full    = (r_count == LP_FULL);
   assign w_empty   = (r_count == '0);
   assign w_job_acc = job_valid && job_ready;
   assign w_acc     = valid_out && out_ready;
   assign w_pop     = w_acc && !w_empty;
   // The core emits the digest byte-reversed relative to the numeric value compared with the target.
   assign w_hit     = (f_bswap(out) <= r_target);

`ifdef STOP_ON_FIRST_HIT_EN
   logic r_hit_seen;
   assign w_report = w_pop && w_hit && !r_hit_seen;
   assign w_stop   = w_report;
   always_ff @(posedge clk) begin
      if (!rst_n)         r_hit_seen <= 1'b0;
      else if (w_job_acc) r_hit_seen <= 1'b0;
      else if (w_report)  r_hit_seen <= 1'b1;
   end
   assign w_issue = (r_state == S_ISSUE) && scrypt_ready && (r_remaining != 32'd0) && !w_full
                    && !r_valid_in && !abort && !r_hit_seen;
`else
   assign w_report = w_pop && w_hit;
   assign w_stop   = 1'b0;
   assign w_issue  = (r_state == S_ISSUE) && scrypt_ready && (r_remaining != 32'd0) && !w_full
                     && !r_valid_in && !abort;
`endif

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (job_valid) w_next = (job_nonce_count == 32'd0) ? S_DONE : S_ISSUE;
         S_ISSUE: if (abort || w_stop || (r_remaining == 32'd0) || (w_issue && r_remaining == 32'd1))
                     w_next = S_DRAIN;
         S_DRAIN: if (w_empty && !w_acc) w_next = S_DONE;
         S_DONE:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_template    <= '0;
         r_nonce       <= '0;
         r_remaining   <= '0;
         r_target      <= '0;
         r_blockheader <= '0;
         r_valid_in    <= 1'b0;
         r_wr_ptr      <= '0;
         r_rd_ptr      <= '0;
         r_count       <= '0;
         r_found_valid <= 1'b0;
         r_found_nonce <= '0;
         r_found_hash  <= '0;
         r_err_orphan  <= 1'b0;
      end else begin
         r_valid_in <= w_issue;
         if (w_job_acc) begin
            r_template  <= job_header[WIDTH_IN-1:32];
            r_nonce     <= job_nonce_start;
            r_remaining <= job_nonce_count;
            r_target    <= job_target;
         end
         if (w_issue) begin
            r_blockheader <= {r_template, r_nonce[7:0], r_nonce[15:8], r_nonce[23:16], r_nonce[31:24]};
            r_wr_ptr      <= r_wr_ptr + 1'b1;
            r_nonce       <= r_nonce + 32'd1;
            r_remaining   <= r_remaining - 32'd1;
         end
         if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_issue, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
         if (w_acc && w_empty) r_err_orphan <= 1'b1;
         if (w_report) begin
            r_found_valid <= 1'b1;
            r_found_nonce <= r_fifo[r_rd_ptr];
            r_found_hash  <= out;
         end else if (found_ready) begin
            r_found_valid <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (w_issue) r_fifo[r_wr_ptr] <= r_nonce;
   end

   assign job_ready   = (r_state == S_IDLE);
   assign busy        = (r_state == S_ISSUE) || (r_state == S_DRAIN);
   assign done        = (r_state == S_DONE);
   assign out_ready   = !(r_found_valid && !found_ready);
   assign blockheader = r_blockheader;
   assign valid_in    = r_valid_in;
   assign found_valid = r_found_valid;
   assign found_nonce = r_found_nonce;
   assign found_hash  = r_found_hash;
   assign err_orphan  = r_err_orphan;
   assign dbg_state   = r_state;
endmodule

// File: tb/tb_scrypt_nonce_dispatcher.sv
// Bench for scrypt_nonce_dispatcher: behavioural scrypt core, hit reference model and found scoreboard.
`timescale 1ns/1ps
module tb_scrypt_nonce_dispatcher;
   localparam int WI = 640;
   localparam int WO = 256;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic          job_valid = 1'b0, job_ready, abort = 1'b0;
   logic [WI-1:0] job_header = '0, blockheader;
   logic [31:0]   job_nonce_start = '0, job_nonce_count = '0, found_nonce;
   logic [WO-1:0] job_target = '0, out, found_hash;
   logic          valid_in, scrypt_ready, valid_out, out_ready, found_valid, found_ready;
   logic          busy, done, err_orphan;
   logic [1:0]    dbg_state;

   scrypt_nonce_dispatcher #(.WIDTH_IN(WI), .WIDTH_OUT(WO), .FIFO_DEPTH(4)) dut (
      .clk(clk), .rst_n(rst_n), .job_valid(job_valid), .job_ready(job_ready), .job_header(job_header),
      .job_nonce_start(job_nonce_start), .job_nonce_count(job_nonce_count), .job_target(job_target),
      .abort(abort), .blockheader(blockheader), .valid_in(valid_in), .scrypt_ready(scrypt_ready),
      .out(out), .valid_out(valid_out), .out_ready(out_ready), .found_valid(found_valid),
      .found_ready(found_ready), .found_nonce(found_nonce), .found_hash(found_hash), .busy(busy),
      .done(done), .err_orphan(err_orphan), .dbg_state(dbg_state));

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [WI-1:0] act, input logic [WI-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   // Numeric value a nonce hashes to; the core emits it byte-reversed.
   function automatic logic [WO-1:0] ref_val(input logic [31:0] n);
      logic [31:0] m;
      m = (n * 32'h9E3779B9) | 32'h1;
      return {n ^ 32'h2, {7{m}}};
   endfunction

   function automatic logic [WO-1:0] bswap256(input logic [WO-1:0] d);
      logic [WO-1:0] r;
      for (int i = 0; i < 32; i++) r[8*i +: 8] = d[8*(31-i) +: 8];
      return r;
   endfunction

   function automatic logic [31:0] bswap32(input logic [31:0] d);
      return {d[7:0], d[15:8], d[23:16], d[31:24]};
   endfunction

   logic [287:0] exp_q[$];       // {nonce, hash} of each hit that must be reported
   logic [31:0]  exp_iss_q[$];   // nonces still expected to be issued
   logic [WI-1:0] cur_tmpl;
   logic [WO-1:0] cur_target;
   bit job_hit = 0;

   // ---------------- core model and found_ready driver ----------------
   logic [WO-1:0] pend_h[$];
   int            pend_t[$];
   int  cyc = 0, core_lat = 20, core_max = 1, issued_cnt = 0, max_inflight = 0;
   int  fr_hold = 0;
   bit  fr_rand = 0, acc_pend = 0, prev_vin = 0, or_low_seen = 0;

   initial begin
      logic [31:0] n, en;
      valid_out = 1'b0; out = '0; scrypt_ready = 1'b1; found_ready = 1'b1;
      forever begin
         @(negedge clk);
         cyc++;
         if (acc_pend && pend_h.size() > 0) begin
            void'(pend_h.pop_front());
            void'(pend_t.pop_front());
         end
         if (valid_in) begin
            chk("issue_spacing", WI'(prev_vin), WI'(0));
            n = bswap32(blockheader[31:0]);
            pend_h.push_back(bswap256(ref_val(n)));
            pend_t.push_back(cyc + core_lat);
            issued_cnt++;
            if (pend_h.size() > max_inflight) max_inflight = pend_h.size();
            if (exp_iss_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_issue: got nonce %0h expected none", n);
            end else begin
               en = exp_iss_q.pop_front();
               chk("issue_header", blockheader, {cur_tmpl[WI-1:32], bswap32(en)});
               if (ref_val(en) <= cur_target) begin
`ifdef STOP_ON_FIRST_HIT_EN
                  if (!job_hit) exp_q.push_back({en, bswap256(ref_val(en))});
`else
                  exp_q.push_back({en, bswap256(ref_val(en))});
`endif
                  job_hit = 1;
               end
            end
         end
         prev_vin = valid_in;
         valid_out = (pend_h.size() > 0) && (pend_t[0] <= cyc);
         out = valid_out ? pend_h[0] : '0;
         scrypt_ready = (pend_h.size() < core_max);
         if (fr_hold > 0) begin
            found_ready = 1'b0;
            fr_hold--;
         end else begin
            found_ready = fr_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
         end
         #1;
         acc_pend = valid_out && out_ready;
         if (!out_ready) or_low_seen = 1;
      end
   end

   // ---------------- scoreboard monitor ----------------
   int done_cnt = 0;
   initial begin
      logic [287:0] e;
      forever begin
         @(negedge clk);
         #2;
         if (done) done_cnt++;
         if (found_valid && found_ready) begin
            if (exp_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_found: got nonce %0h expected none", found_nonce);
            end else begin
               e = exp_q.pop_front();
               chk("found_nonce", WI'(found_nonce), WI'(e[287:256]));
               chk("found_hash", WI'(found_hash), WI'(e[255:0]));
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic check_reset_values();
      chk("rst_job_ready", WI'(job_ready), WI'(1));
      chk("rst_out_ready", WI'(out_ready), WI'(1));
      chk("rst_busy", WI'(busy), WI'(0));
      chk("rst_done", WI'(done), WI'(0));
      chk("rst_valid_in", WI'(valid_in), WI'(0));
      chk("rst_found_valid", WI'(found_valid), WI'(0));
      chk("rst_err_orphan", WI'(err_orphan), WI'(0));
      chk("rst_blockheader", blockheader, WI'(0));
      chk("rst_found_nonce", WI'(found_nonce), WI'(0));
      chk("rst_found_hash", WI'(found_hash), WI'(0));
      chk("rst_state", WI'(dbg_state), WI'(0));
   endtask

   task automatic start_job(input logic [WI-1:0] hdr, input logic [31:0] start, input logic [31:0] cnt,
                            input logic [WO-1:0] tgt);
      int t;
      t = 0;
      while (!job_ready && t < 200) begin
         @(negedge clk); #3; t++;
      end
      if (!job_ready) begin
         checks++; errors++;
         $display("FAIL job_ready_timeout: got 0 expected 1");
      end
      cur_tmpl = hdr; cur_target = tgt; job_hit = 0;
      for (int i = 0; i < int'(cnt); i++) exp_iss_q.push_back(start + 32'(i));
      job_header = hdr; job_nonce_start = start; job_nonce_count = cnt; job_target = tgt;
      job_valid = 1'b1;
   endtask

   task automatic run_job(input logic [WI-1:0] hdr, input logic [31:0] start, input logic [31:0] cnt,
                          input logic [WO-1:0] tgt, input int abort_after, output int lat);
      int base_iss, base_done, t;
      bit got, aborted, lenient;
      base_iss = issued_cnt; base_done = done_cnt;
      start_job(hdr, start, cnt, tgt);
      lat = 0; got = 0; aborted = 0;
      while (lat < 3000) begin
         @(negedge clk); #3;
         job_valid = 1'b0;
         abort = 1'b0;
         lat++;
         if (done) begin got = 1; break; end
         if (abort_after > 0 && !aborted && issued_cnt - base_iss >= abort_after) begin
            abort = 1'b1; aborted = 1;
         end
      end
      abort = 1'b0;
      chk("done_seen", WI'(got), WI'(1));
      lenient = 0;
`ifdef STOP_ON_FIRST_HIT_EN
      lenient = job_hit;
`endif
      if (!lenient) begin
         if (abort_after > 0) chk("abort_issue_count", WI'(issued_cnt - base_iss), WI'(abort_after));
         else                 chk("all_issued", WI'(exp_iss_q.size()), WI'(0));
      end
      exp_iss_q.delete();
      @(negedge clk); #3;
      chk("done_one_cycle", WI'(done), WI'(0));
      chk("done_pulse_count", WI'(done_cnt), WI'(base_done + 1));
      t = 0;
      while (exp_q.size() != 0 && t < 200) begin
         @(negedge clk); #3; t++;
      end
      chk("founds_drained", WI'(exp_q.size()), WI'(0));
   endtask

   function automatic logic [WI-1:0] rand_hdr();
      logic [WI-1:0] h;
      for (int w = 0; w < 20; w++) h[32*w +: 32] = $urandom;
      return h;
   endfunction

   // ---------------- test sequence ----------------
   initial begin
      int lat, base_iss, t;
      logic [WO-1:0] tgt;
      logic [31:0] st, cn;
      int ab;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      #3;
      check_reset_values();
      rst_n = 1'b1;
      @(negedge clk); #3;

      // Three nonces, single-outstanding core, every hash a hit.
      core_lat = 20; core_max = 1;
      run_job(rand_hdr(), 32'h10, 32'd3, {WO{1'b1}}, 0, lat);

      // Zero-length job.
      base_iss = issued_cnt;
      run_job(rand_hdr(), 32'h55, 32'd0, {WO{1'b1}}, 0, lat);
      chk("count0_done_latency", WI'(lat <= 2), WI'(1));
      chk("count0_no_issue", WI'(issued_cnt - base_iss), WI'(0));

      // Nonce wraparound, nothing meets a zero target.
      run_job(rand_hdr(), 32'hFFFF_FFFE, 32'd3, '0, 0, lat);

      // Deep core, only nonce 2 hits, found consumer stalled.
      core_lat = 20; core_max = 8; fr_hold = 50; max_inflight = 0; or_low_seen = 0;
      run_job(rand_hdr(), 32'h0, 32'd8, {32'h0, {224{1'b1}}}, 0, lat);
      chk("fifo_depth_limit", WI'(max_inflight), WI'(4));
      chk("out_ready_dropped", WI'(or_low_seen), WI'(1));

      // Abort after two issues.
      core_lat = 20; core_max = 4;
      run_job(rand_hdr(), 32'h200, 32'd10, {WO{1'b1}}, 2, lat);

      // Two hits in one job (only the first is expected when stopping on first hit).
      core_lat = 12; core_max = 2;
      run_job(rand_hdr(), 32'h0, 32'd8, {32'h1, {224{1'b1}}}, 0, lat);

      // Target boundary: equal is a hit, one below is a miss.
      core_lat = 5; core_max = 1;
      run_job(rand_hdr(), 32'h13, 32'd1, ref_val(32'h13), 0, lat);
      run_job(rand_hdr(), 32'h13, 32'd1, ref_val(32'h13) - 1'b1, 0, lat);

      // Randomised jobs.
      fr_rand = 1;
      for (int j = 0; j < 8; j++) begin
         core_lat = $urandom_range(2, 25);
         core_max = $urandom_range(1, 6);
         st = $urandom;
         cn = $urandom_range(1, 8);
         tgt = {(st ^ 32'h2) + 32'($urandom_range(0, 6)), 32'($urandom), 192'(0)};
         if ($urandom_range(0, 3) == 0) tgt = {WO{1'b1}};
         ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, cn)) : 0;
         run_job(rand_hdr(), st, cn, tgt, ab, lat);
      end
      fr_rand = 0;

      // Reset mid-job; the core then returns stale hashes.
      core_lat = 40; core_max = 4;
      base_iss = issued_cnt;
      start_job(rand_hdr(), 32'h300, 32'd4, {WO{1'b1}});
      t = 0;
      while (issued_cnt - base_iss < 2 && t < 100) begin
         @(negedge clk); #3; job_valid = 1'b0; t++;
      end
      job_valid = 1'b0;
      chk("pre_reset_issues", WI'(issued_cnt - base_iss), WI'(2));
      rst_n = 1'b0;
      exp_iss_q.delete();
      exp_q.delete();
      repeat (2) @(negedge clk);
      #3;
      check_reset_values();
      rst_n = 1'b1;
      t = 0;
      while (!err_orphan && t < 200) begin
         @(negedge clk); #3; t++;
      end
      chk("err_orphan_set", WI'(err_orphan), WI'(1));
      t = 0;
      while (pend_h.size() != 0 && t < 200) begin
         @(negedge clk); #3; t++;
      end
      repeat (3) @(negedge clk);
      #3;
      chk("err_orphan_sticky", WI'(err_orphan), WI'(1));
      chk("orphan_no_found", WI'(found_valid), WI'(0));
      chk("final_exp_empty", WI'(exp_q.size()), WI'(0));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #3_000_000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end
endmodule
